i2c_bus_sched: RTL and testbench

//  Round-robin scheduler sharing one I2C master (ADV7513 / camera config bus)

---
 rtl/i2c_bus_sched.sv | 192 +++++++++++++++++++
 tb/tb_i2c_bus_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_sched.sv
// Round-robin owner of one shared I2C master: serialises requester transactions,
// enforces a post-transaction guard gap and a per-transaction watchdog.
module i2c_bus_sched #(
   parameter int N_REQ          = 3,
   parameter int GUARD_CYCLES   = 30000,
   parameter int TIMEOUT_CYCLES = 5000000,
   parameter int CNT_W          = 29
) (
   input  logic                 CLOCK_50_B5B,
   input  logic                 RESET,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ-1:0]     req_rw,
   input  logic [7*N_REQ-1:0]   req_chip,
   input  logic [8*N_REQ-1:0]   req_reg,
   input  logic [8*N_REQ-1:0]   req_wdata,
   output logic [N_REQ-1:0]     grant,
   output logic [N_REQ-1:0]     req_done,
   output logic [N_REQ-1:0]     req_err,
   output logic [7:0]           rdata,
   output logic                 m_start,
   output logic                 m_rw,
   output logic [6:0]           m_chip,
   output logic [7:0]           m_reg,
   output logic [7:0]           m_wdata,
   output logic                 m_abort,
   input  logic                 m_done,
   input  logic                 m_nack,
   input  logic [7:0]           m_rdata,
   output logic                 busy
);

   // state | meaning
   // IDLE  | bus free, arbitrating among req_valid
   // ISSUE | command latched, m_start launched on exit
   // WAIT  | master running; watching m_done and the watchdog
   // GUARD | mandatory idle gap, requests ignored
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GUARD} state_t;

   localparam int LG_W       = (N_REQ > 2) ? $clog2(N_REQ) : 1;
   localparam int GUARD_LAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [LG_W-1:0]     r_last;
   logic [LG_W-1:0]     r_gidx;
   logic [CNT_W-1:0]    r_cnt;

   logic [2*N_REQ-1:0]  w_dbl;
   logic [N_REQ-1:0]    w_rot;
   logic [LG_W:0]       w_base;
   logic [LG_W:0]       w_off;
   logic [LG_W:0]       w_sum;
   logic [LG_W-1:0]     w_pick;
   logic [N_REQ-1:0]    w_onehot;
   logic                w_found;
   logic                w_rw;
   logic [6:0]          w_chip;
   logic [7:0]          w_reg;
   logic [7:0]          w_wdata;
   logic                w_tmo_hit;
   logic                w_guard_end;
   logic                w_load;
   logic                w_issue;
   logic                w_complete;
   logic                w_timeout;

   // Rotate the request vector so the requester after the last owner sits at bit 0.
   assign w_dbl    = {req_valid, req_valid};
   assign w_base   = {1'b0, r_last} + (LG_W+1)'(1);
   assign w_rot    = N_REQ'(w_dbl >> w_base);
   assign w_sum    = w_base + w_off;
   assign w_onehot = N_REQ'(1) << w_pick;

   always_comb begin
      w_found = 1'b0;
      w_off   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_found = 1'b1;
            w_off   = (LG_W+1)'(k);
         end
      end
   end

   always_comb begin
      if (w_sum >= (LG_W+1)'(N_REQ))
         w_pick = LG_W'(w_sum - (LG_W+1)'(N_REQ));
      else
         w_pick = LG_W'(w_sum);
   end

   always_comb begin
      w_rw    = 1'b0;
      w_chip  = '0;
      w_reg   = '0;
      w_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_pick == LG_W'(i)) begin
            w_rw    = req_rw[i];
            w_chip  = req_chip[7*i +: 7];
            w_reg   = req_reg[8*i +: 8];
            w_wdata = req_wdata[8*i +: 8];
         end
      end
   end

   assign w_tmo_hit   = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_guard_end = (r_cnt >= CNT_W'(GUARD_LAST));

   always_ff @(posedge CLOCK_50_B5B) begin
      if (!RESET)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT:  if (m_done || w_tmo_hit) w_state_nxt = S_GUARD;
         S_GUARD: if (w_guard_end) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // m_done has priority over a watchdog expiry in the same cycle.
   always_comb begin
      w_load     = (r_state == S_IDLE) && w_found;
      w_issue    = (r_state == S_ISSUE);
      w_complete = (r_state == S_WAIT) && m_done;
      w_timeout  = (r_state == S_WAIT) && !m_done && w_tmo_hit;
      busy       = (r_state != S_IDLE);
   end

   always_ff @(posedge CLOCK_50_B5B) begin
      if (!RESET) begin
         grant    <= '0;
         req_done <= '0;
         req_err  <= '0;
         rdata    <= '0;
         m_start  <= 1'b0;
         m_abort  <= 1'b0;
         m_rw     <= 1'b0;
         m_chip   <= '0;
         m_reg    <= '0;
         m_wdata  <= '0;
         r_last   <= LG_W'(N_REQ - 1);
         r_gidx   <= '0;
         r_cnt    <= '0;
      end else begin
         m_start  <= w_issue;
         m_abort  <= w_timeout;
         req_done <= '0;
         req_err  <= '0;
         if (w_load) begin
            grant   <= w_onehot;
            r_gidx  <= w_pick;
            m_rw    <= w_rw;
            m_chip  <= w_chip;
            m_reg   <= w_reg;
            m_wdata <= w_wdata;
         end
         if (w_complete || w_timeout) begin
            req_done <= grant;
            req_err  <= (w_timeout || m_nack) ? grant : '0;
            grant    <= '0;
            r_last   <= r_gidx;
         end
         if (w_complete && m_rw)
            rdata <= m_rdata;
         case (r_state)
            S_ISSUE: r_cnt <= '0;
            S_WAIT: begin
               if (w_complete || w_timeout)
                  r_cnt <= '0;
               else if (r_cnt != '1)
                  r_cnt <= r_cnt + CNT_W'(1);
            end
            S_GUARD: begin
               if (w_guard_end)
                  r_cnt <= '0;
               else if (r_cnt != '1)
                  r_cnt <= r_cnt + CNT_W'(1);
            end
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_bus_sched.sv
// Bench for i2c_bus_sched: timeline model (pick cycle, start, completion, guard end)
// compared every cycle, plus directed scenarios with literal expectations.
module tb_i2c_bus_sched;

   localparam int N = 3;
   localparam int G = 20;
   localparam int T = 100;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   req_valid, req_rw;
   logic [20:0]  req_chip;
   logic [23:0]  req_reg, req_wdata;
   logic [2:0]   grant, req_done, req_err;
   logic [7:0]   rdata, m_reg, m_wdata, m_rdata;
   logic [6:0]   m_chip;
   logic         m_start, m_rw, m_abort, m_done, m_nack, busy;

   i2c_bus_sched #(.N_REQ(N), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(T), .CNT_W(29)) dut (
      .CLOCK_50_B5B(clk), .RESET(rst_n),
      .req_valid(req_valid), .req_rw(req_rw), .req_chip(req_chip),
      .req_reg(req_reg), .req_wdata(req_wdata),
      .grant(grant), .req_done(req_done), .req_err(req_err), .rdata(rdata),
      .m_start(m_start), .m_rw(m_rw), .m_chip(m_chip), .m_reg(m_reg),
      .m_wdata(m_wdata), .m_abort(m_abort), .m_done(m_done), .m_nack(m_nack),
      .m_rdata(m_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_miss = 0;
   int cyc = 0;

   // transaction timeline: picked at posedge n, m_start in cycle s, outcome visible in cycle e
   int have = 0, n_c, s_c, e_c, g_c, tmo_c, rd_c, nack_c, rdv_c;
   int d_plan = -1, spur = 0, late = -1, free_from = 1, last_m = N - 1;
   logic       mrw_m;
   logic [6:0] mchip_m;
   logic [7:0] mreg_m, mwd_m, rdata_m;
   logic [2:0] exp_grant, exp_done, exp_err;
   logic       exp_start, exp_abort, exp_busy;
   int plan_force = -1, force_delay = 0, force_nack = 0, force_rdata = 0;
   int keep_on_done = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic expire(input string nm, input int budget);
      n_vec++;
      n_miss++;
      $display("FAIL %s: no event within %0d cycles (cycle %0d)", nm, budget, cyc);
   endtask

   function automatic int rr_pick(input logic [2:0] v, input int lst);
      for (int k = 1; k <= N; k++)
         if (v[(lst + k) % N]) return (lst + k) % N;
      return -1;
   endfunction

   task automatic model_posedge();
      int kind;
      if (!rst_n) begin
         have = 0; free_from = cyc + 1; last_m = N - 1;
         mrw_m = 0; mchip_m = 0; mreg_m = 0; mwd_m = 0; rdata_m = 0;
         d_plan = -1; late = -1; spur = 0;
      end else begin
         if (have != 0 && cyc == e_c && rd_c != 0 && tmo_c == 0) rdata_m = rdv_c[7:0];
         if (cyc >= free_from && req_valid != 3'b000) begin
            g_c = rr_pick(req_valid, last_m);
            last_m = g_c;
            have = 1; n_c = cyc; s_c = cyc + 1;
            rd_c = int'(req_rw[g_c]);
            mrw_m = req_rw[g_c];
            mchip_m = req_chip[7*g_c +: 7];
            mreg_m = req_reg[8*g_c +: 8];
            mwd_m = req_wdata[8*g_c +: 8];
            if (plan_force == 0) kind = 0;
            else if (plan_force == 1) kind = 99;
            else kind = int'($urandom_range(0, 11));
            nack_c = (plan_force >= 0) ? force_nack : int'($urandom_range(0, 3) == 0);
            rdv_c  = (plan_force >= 0) ? force_rdata : int'($urandom_range(0, 255));
            late = -1;
            if (kind == 0) begin
               tmo_c = 1; d_plan = -1; e_c = s_c + T;
               if ($urandom_range(0, 1) == 1) late = e_c + 2;
            end else begin
               tmo_c = 0;
               if (kind == 99) d_plan = s_c + force_delay;
               else if (kind == 1) d_plan = s_c + T - 1;
               else if (kind == 2) d_plan = s_c;
               else d_plan = s_c + int'($urandom_range(1, 15));
               e_c = d_plan + 1;
            end
            spur = int'($urandom_range(0, 1));
            free_from = e_c + G + 1;
         end
      end
   endtask

   task automatic model_expect();
      logic [2:0] oh;
      oh = 3'b001 << g_c;
      exp_busy  = (have != 0) && cyc >= n_c && cyc < e_c + G;
      exp_grant = ((have != 0) && cyc >= n_c && cyc < e_c) ? oh : 3'b000;
      exp_start = (have != 0) && cyc == s_c;
      exp_done  = ((have != 0) && cyc == e_c) ? oh : 3'b000;
      exp_err   = ((have != 0) && cyc == e_c && (tmo_c != 0 || nack_c != 0)) ? oh : 3'b000;
      exp_abort = (have != 0) && cyc == e_c && tmo_c != 0;
   endtask

   task automatic drive_master();
      bit hit;
      hit = (have != 0) && cyc == d_plan;
      m_done  = (have != 0) && (hit || (spur != 0 && cyc == n_c) || cyc == late);
      m_nack  = hit ? nack_c[0] : 1'($urandom_range(0, 1));
      m_rdata = hit ? rdv_c[7:0] : 8'($urandom_range(0, 255));
      if (have != 0 && cyc == e_c && keep_on_done == 0) req_valid[g_c] = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      cyc++;
      model_posedge();
      model_expect();
      drive_master();
      chk_en = 1'b1;
   endtask

   function automatic bit evt(input int k);
      case (k)
         0: return req_done != 3'b000;
         1: return m_start == 1'b1;
         2: return busy == 1'b0;
         default: return m_abort == 1'b1;
      endcase
   endfunction

   task automatic wait_evt(input string nm, input int k, input int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (evt(k)) return;
      end
      expire(nm, budget);
   endtask

   task automatic raise(input int i, input logic rw, input logic [6:0] ch,
                        input logic [7:0] rg, input logic [7:0] wd);
      req_valid[i] = 1'b1;
      req_rw[i] = rw;
      req_chip[7*i +: 7] = ch;
      req_reg[8*i +: 8] = rg;
      req_wdata[8*i +: 8] = wd;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("grant", grant, exp_grant);
         check("busy", busy, exp_busy);
         check("m_start", m_start, exp_start);
         check("m_abort", m_abort, exp_abort);
         check("req_done", req_done, exp_done);
         check("req_err", req_err, exp_err);
         check("rdata", rdata, rdata_m);
         check("m_rw", m_rw, mrw_m);
         check("m_chip", m_chip, mchip_m);
         check("m_reg", m_reg, mreg_m);
         check("m_wdata", m_wdata, mwd_m);
      end
   end

   initial begin
      logic [2:0] order[4];
      logic [2:0] t2_exp[4];
      int tst[4];
      int starts, t0, t5s, t5a;
      t2_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
      rst_n = 1'b0; req_valid = '0; req_rw = '0; req_chip = '0; req_reg = '0; req_wdata = '0;
      m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
      mrw_m = 0; mchip_m = 0; mreg_m = 0; mwd_m = 0; rdata_m = 0; g_c = 0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_grant", grant, 0);
      rst_n = 1'b1;
      tick();

      // single write
      plan_force = 1; force_delay = 3; force_nack = 0; force_rdata = 8'h3C;
      raise(0, 1'b0, 7'd39, 8'd41, 8'd10);
      t0 = cyc;
      tick();
      tick();
      check("t1_start_lat", cyc - t0, 2);
      check("t1_start", m_start, 1);
      check("t1_chip", m_chip, 39);
      check("t1_reg", m_reg, 41);
      check("t1_wdata", m_wdata, 10);
      wait_evt("t1_done", 0, 50);
      check("t1_done", req_done, 3'b001);
      check("t1_err", req_err, 3'b000);
      wait_evt("t1_idle", 2, G + 10);

      // contention from a fresh reset
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      keep_on_done = 1; force_delay = 0;
      raise(0, 1'b0, 7'h10, 8'h01, 8'h11);
      raise(1, 1'b0, 7'h20, 8'h02, 8'h22);
      raise(2, 1'b0, 7'h30, 8'h03, 8'h33);
      starts = 0;
      for (int i = 0; i < 4 * (G + 10) && starts < 4; i++) begin
         tick();
         if (m_start) begin
            order[starts] = grant;
            tst[starts] = cyc;
            starts++;
         end
      end
      req_valid = '0;
      keep_on_done = 0;
      check("t2_count", starts, 4);
      for (int k = 0; k < 4 && k < starts; k++) check("t2_order", order[k], t2_exp[k]);
      for (int k = 1; k < 4 && k < starts; k++) check("t2_gap_ok", (tst[k] - tst[k-1]) >= G + 3, 1);
      wait_evt("t2_idle", 2, G + 20);

      // read returns data
      force_delay = 5; force_rdata = 8'hA5;
      raise(1, 1'b1, 7'h21, 8'h10, 8'h00);
      wait_evt("t3_done", 0, 50);
      check("t3_done", req_done, 3'b010);
      check("t3_err", req_err, 3'b000);
      check("t3_rdata", rdata, 8'hA5);
      wait_evt("t3_idle", 2, G + 10);

      // NACK, then the other requester still served
      force_nack = 1; force_rdata = 8'h5A;
      raise(2, 1'b0, 7'h39, 8'h20, 8'h44);
      raise(0, 1'b0, 7'h39, 8'h21, 8'h55);
      wait_evt("t4_done1", 0, 50);
      check("t4_done1", req_done, 3'b100);
      check("t4_err1", req_err, 3'b100);
      force_nack = 0;
      wait_evt("t4_done2", 0, G + 50);
      check("t4_done2", req_done, 3'b001);
      check("t4_err2", req_err, 3'b000);
      wait_evt("t4_idle", 2, G + 10);

      // watchdog
      plan_force = 0;
      raise(0, 1'b1, 7'h3F, 8'h30, 8'h00);
      wait_evt("t5_start", 1, 10);
      t5s = cyc;
      wait_evt("t5_abort", 3, T + 50);
      t5a = cyc;
      check("t5_tmo_cycle", t5a - t5s, T);
      check("t5_done", req_done, 3'b001);
      check("t5_err", req_err, 3'b001);
      check("t5_rdata_kept", rdata, 8'hA5);
      wait_evt("t5_idle", 2, G + 10);
      check("t5_guard_len", cyc - t5a, G);

      // reset while waiting on the master
      plan_force = 1; force_delay = 30;
      raise(1, 1'b0, 7'h11, 8'h40, 8'h66);
      wait_evt("t6_start", 1, 10);
      tick(); tick();
      rst_n = 1'b0;
      tick();
      check("t6_grant", grant, 3'b000);
      check("t6_busy", busy, 0);
      check("t6_done", req_done, 3'b000);
      rst_n = 1'b1; req_valid = '0;
      repeat (3) tick();

      // randomized traffic
      plan_force = -1;
      for (int it = 0; it < 3000; it++) begin
         rst_n = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 5) == 0)
               raise(i, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
                     8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            else if (req_valid[i] && $urandom_range(0, 199) == 0)
               req_valid[i] = 1'b0;
         end
         keep_on_done = ($urandom_range(0, 7) == 0) ? 1 : 0;
         if (have != 0 && cyc > s_c && cyc < e_c - 1 && $urandom_range(0, 49) == 0) rst_n = 1'b0;
         tick();
      end
      rst_n = 1'b1; req_valid = '0; keep_on_done = 0;
      wait_evt("drain_idle", 2, T + G + 50);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
